// File: rtl/uart_cmd_bridge_if.sv
// Parallel-side connection of uart_cmd_bridge: UART RX/TX byte streams and
// the single-byte on-chip bus.
interface uart_cmd_bridge_if;
    // UART receive stream (UART -> bridge)
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    // UART transmit stream (bridge -> UART)
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    // On-chip bus (bridge issues requests)
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;

    // Host side: supplies command bytes, drains replies, answers bus requests.
    modport master (
        output rx_byte, rx_valid, tx_ready, bus_ack, bus_rdata,
        input  rx_ready, tx_byte, tx_valid, bus_req, bus_we, bus_addr, bus_wdata
    );

    // Bridge side: responds to commands.
    modport slave (
        input  rx_byte, rx_valid, tx_ready, bus_ack, bus_rdata,
        output rx_ready, tx_byte, tx_valid, bus_req, bus_we, bus_addr, bus_wdata
    );
endinterface

// File: rtl/uart_cmd_bridge.sv
// Byte-level command responder: parses 'W'/'R' host commands from the UART
// RX stream, performs one bus access and returns a single reply byte.
module uart_cmd_bridge #(
    parameter int unsigned BUS_TIMEOUT  = 255,
    parameter int unsigned BYTE_TIMEOUT = 65535
) (
    input logic             clock,
    input logic             reset,
    uart_cmd_bridge_if.slave link
);

    localparam logic [7:0]  CMD_WRITE  = 8'h57;
    localparam logic [7:0]  CMD_READ   = 8'h52;
    localparam logic [7:0]  RPL_OK     = 8'h4B;
    localparam logic [7:0]  RPL_BADCMD = 8'h3F;
    localparam logic [7:0]  RPL_ERROR  = 8'h45;
    localparam logic [15:0] BUS_LOAD   = BUS_TIMEOUT[15:0];
    localparam logic [19:0] BYTE_LOAD  = BYTE_TIMEOUT[19:0];

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR_HI,
        S_ADDR_LO,
        S_DATA,
        S_BUS,
        S_REPLY
    } state_t;

    state_t      state;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [15:0] bus_cnt;
    logic [19:0] byte_cnt;
    logic        rx_ready;
    logic        accept;

    // Byte acceptance follows directly from the state register.
    always_comb begin
        rx_ready = (state == S_CMD) || (state == S_ADDR_HI) ||
                   (state == S_ADDR_LO) || (state == S_DATA);
        accept   = rx_ready && link.rx_valid;
    end

    assign link.rx_ready  = rx_ready;
    assign link.tx_byte   = tx_byte;
    assign link.tx_valid  = tx_valid;
    assign link.bus_req   = bus_req;
    assign link.bus_we    = bus_we;
    assign link.bus_addr  = bus_addr;
    assign link.bus_wdata = bus_wdata;

    // Command FSM with registered reply and bus outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_CMD;
            tx_valid  <= 1'b0;
            tx_byte   <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_cnt   <= '0;
            byte_cnt  <= '0;
        end else begin
            unique case (state)
                S_CMD: begin
                    if (accept) begin
                        if (link.rx_byte == CMD_WRITE) begin
                            bus_we   <= 1'b1;
                            byte_cnt <= BYTE_LOAD;
                            state    <= S_ADDR_HI;
                        end else if (link.rx_byte == CMD_READ) begin
                            bus_we   <= 1'b0;
                            byte_cnt <= BYTE_LOAD;
                            state    <= S_ADDR_HI;
                        end else begin
                            tx_byte  <= RPL_BADCMD;
                            tx_valid <= 1'b1;
                            state    <= S_REPLY;
                        end
                    end
                end
                S_ADDR_HI: begin
                    if (accept) begin
                        bus_addr[15:8] <= link.rx_byte;
                        byte_cnt       <= BYTE_LOAD;
                        state          <= S_ADDR_LO;
                    end else if (byte_cnt == '0) begin
                        state <= S_CMD;
                    end else begin
                        byte_cnt <= byte_cnt - 20'd1;
                    end
                end
                S_ADDR_LO: begin
                    if (accept) begin
                        bus_addr[7:0] <= link.rx_byte;
                        if (bus_we) begin
                            byte_cnt <= BYTE_LOAD;
                            state    <= S_DATA;
                        end else begin
                            bus_req <= 1'b1;
                            bus_cnt <= BUS_LOAD;
                            state   <= S_BUS;
                        end
                    end else if (byte_cnt == '0) begin
                        state <= S_CMD;
                    end else begin
                        byte_cnt <= byte_cnt - 20'd1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        bus_wdata <= link.rx_byte;
                        bus_req   <= 1'b1;
                        bus_cnt   <= BUS_LOAD;
                        state     <= S_BUS;
                    end else if (byte_cnt == '0) begin
                        state <= S_CMD;
                    end else begin
                        byte_cnt <= byte_cnt - 20'd1;
                    end
                end
                S_BUS: begin
                    // An ack always wins over an expiring counter.
                    if (bus_req && link.bus_ack) begin
                        bus_req  <= 1'b0;
                        tx_byte  <= bus_we ? RPL_OK : link.bus_rdata;
                        tx_valid <= 1'b1;
                        state    <= S_REPLY;
                    end else if (bus_cnt == '0) begin
                        bus_req  <= 1'b0;
                        tx_byte  <= RPL_ERROR;
                        tx_valid <= 1'b1;
                        state    <= S_REPLY;
                    end else begin
                        bus_cnt <= bus_cnt - 16'd1;
                    end
                end
                S_REPLY: begin
                    if (tx_valid && link.tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_CMD;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    bus_req  <= 1'b0;
                    state    <= S_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed self-checking bench for uart_cmd_bridge (BUS_TIMEOUT=4,
// BYTE_TIMEOUT=10 so both timeouts are reachable in a few cycles).
module tb_uart_cmd_bridge;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests    = 0;
    int   failures = 0;

    uart_cmd_bridge_if link ();

    uart_cmd_bridge #(
        .BUS_TIMEOUT (4),
        .BYTE_TIMEOUT(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .link (link.slave)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until the bridge takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        link.rx_byte  = b;
        link.rx_valid = 1'b1;
        while (!link.rx_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("rx_ready_wait", 32'(n), 32'(0));
        tick();
        link.rx_valid = 1'b0;
    endtask

    // Ack the pending bus request in the current cycle.
    task automatic ack_now(input logic [7:0] d);
        link.bus_rdata = d;
        link.bus_ack   = 1'b1;
        tick();
        link.bus_ack   = 1'b0;
    endtask

    initial begin : stim
        int  n;
        int  activity;
        int  bad;

        link.rx_byte   = 8'h00;
        link.rx_valid  = 1'b0;
        link.tx_ready  = 1'b1;
        link.bus_ack   = 1'b0;
        link.bus_rdata = 8'h00;

        // Reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_rx_ready", 32'(link.rx_ready), 32'h1);
        check("rst_tx_valid", 32'(link.tx_valid), 32'h0);
        check("rst_tx_byte",  32'(link.tx_byte),  32'h00);
        check("rst_bus_req",  32'(link.bus_req),  32'h0);
        check("rst_bus_we",   32'(link.bus_we),   32'h0);
        check("rst_bus_addr", 32'(link.bus_addr), 32'h0000);
        check("rst_bus_wdata",32'(link.bus_wdata),32'h00);

        // Write path, ack 3 cycles after bus_req
        send_byte(8'h57);
        send_byte(8'h12);
        send_byte(8'h34);
        check("wr_no_req_before_data", 32'(link.bus_req), 32'h0);
        send_byte(8'hA5);
        check("wr_req",      32'(link.bus_req),   32'h1);
        check("wr_we",       32'(link.bus_we),    32'h1);
        check("wr_addr",     32'(link.bus_addr),  32'h1234);
        check("wr_wdata",    32'(link.bus_wdata), 32'hA5);
        check("wr_rx_ready", 32'(link.rx_ready),  32'h0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (link.bus_req !== 1'b1 || link.bus_addr !== 16'h1234 ||
                link.bus_wdata !== 8'hA5 || link.bus_we !== 1'b1 || link.tx_valid !== 1'b0)
                bad++;
        end
        check("wr_held_stable", 32'(bad), 32'h0);
        ack_now(8'h00);
        check("wr_req_drop",  32'(link.bus_req),  32'h0);
        check("wr_tx_valid",  32'(link.tx_valid), 32'h1);
        check("wr_reply",     32'(link.tx_byte),  32'h4B);
        tick();
        check("wr_tx_done",   32'(link.tx_valid), 32'h0);
        check("wr_rx_back",   32'(link.rx_ready), 32'h1);

        // Read path, ack in first BUS cycle
        send_byte(8'h52);
        send_byte(8'hBE);
        send_byte(8'hEF);
        check("rd_req",  32'(link.bus_req),  32'h1);
        check("rd_we",   32'(link.bus_we),   32'h0);
        check("rd_addr", 32'(link.bus_addr), 32'hBEEF);
        check("rd_no_tx_yet", 32'(link.tx_valid), 32'h0);
        ack_now(8'h5C);
        check("rd_tx_valid", 32'(link.tx_valid), 32'h1);
        check("rd_reply",    32'(link.tx_byte),  32'h5C);
        check("rd_req_drop", 32'(link.bus_req),  32'h0);
        tick();
        check("rd_tx_done",  32'(link.tx_valid), 32'h0);

        // Invalid command, then a normal read
        send_byte(8'h00);
        check("inv_tx_valid", 32'(link.tx_valid), 32'h1);
        check("inv_reply",    32'(link.tx_byte),  32'h3F);
        check("inv_no_req",   32'(link.bus_req),  32'h0);
        check("inv_rx_ready", 32'(link.rx_ready), 32'h0);
        tick();
        check("inv_tx_done",  32'(link.tx_valid), 32'h0);
        check("inv_rx_back",  32'(link.rx_ready), 32'h1);
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h01);
        check("inv_rd_addr", 32'(link.bus_addr), 32'h0001);
        check("inv_rd_we",   32'(link.bus_we),   32'h0);
        ack_now(8'h77);
        check("inv_rd_reply", 32'(link.tx_byte), 32'h77);
        tick();

        // Bus timeout: no ack, bus_req high for BUS_TIMEOUT+1 cycles
        send_byte(8'h52);
        send_byte(8'hAB);
        send_byte(8'hCD);
        n = 0;
        while (link.bus_req && n < 20) begin
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd5);
        check("to_tx_valid",   32'(link.tx_valid), 32'h1);
        check("to_reply",      32'(link.tx_byte),  32'h45);
        // Late ack while replying is ignored
        ack_now(8'h11);
        check("to_late_ack_req",  32'(link.bus_req),  32'h0);
        check("to_late_ack_byte", 32'(link.tx_byte),  32'h45);
        check("to_tx_done",       32'(link.tx_valid), 32'h0);

        // Ack in the 5th BUS cycle (counter at 0) wins
        send_byte(8'h52);
        send_byte(8'hAB);
        send_byte(8'hCE);
        for (int i = 0; i < 4; i++) tick();
        check("to5_req_still", 32'(link.bus_req), 32'h1);
        ack_now(8'h99);
        check("to5_tx_valid", 32'(link.tx_valid), 32'h1);
        check("to5_reply",    32'(link.tx_byte),  32'h99);
        tick();

        // Byte timeout: stall after 'W', addr_hi; must silently return to CMD
        send_byte(8'h57);
        send_byte(8'h00);
        activity = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (link.bus_req !== 1'b0 || link.tx_valid !== 1'b0) activity++;
        end
        check("bto_silent", 32'(activity), 32'h0);
        send_byte(8'h52);
        send_byte(8'h01);
        send_byte(8'h02);
        check("bto_req",  32'(link.bus_req),  32'h1);
        check("bto_we",   32'(link.bus_we),   32'h0);
        check("bto_addr", 32'(link.bus_addr), 32'h0102);
        ack_now(8'h3C);
        check("bto_reply", 32'(link.tx_byte), 32'h3C);
        tick();

        // Short stall below the byte timeout keeps the command alive
        send_byte(8'h57);
        send_byte(8'h00);
        for (int i = 0; i < 8; i++) tick();
        send_byte(8'h10);
        send_byte(8'hEE);
        check("bshort_we",    32'(link.bus_we),    32'h1);
        check("bshort_addr",  32'(link.bus_addr),  32'h0010);
        check("bshort_wdata", 32'(link.bus_wdata), 32'hEE);
        ack_now(8'h00);
        check("bshort_reply", 32'(link.tx_byte), 32'h4B);
        tick();

        // Backpressure: tx_ready low for 20 cycles in REPLY
        link.tx_ready = 1'b0;
        send_byte(8'h41);
        link.rx_byte  = 8'h52;
        link.rx_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (link.tx_valid !== 1'b1 || link.tx_byte !== 8'h3F || link.rx_ready !== 1'b0)
                bad++;
            tick();
        end
        link.rx_valid = 1'b0;
        check("bp_stable", 32'(bad), 32'h0);
        link.tx_ready = 1'b1;
        tick();
        check("bp_tx_done",  32'(link.tx_valid), 32'h0);
        check("bp_rx_back",  32'(link.rx_ready), 32'h1);
        link.tx_ready = 1'b1;

        // Reset while bus_req is high
        send_byte(8'h52);
        send_byte(8'h12);
        send_byte(8'h34);
        check("rm_req_up", 32'(link.bus_req), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_req",      32'(link.bus_req),  32'h0);
        check("rm_tx_valid", 32'(link.tx_valid), 32'h0);
        check("rm_rx_ready", 32'(link.rx_ready), 32'h1);
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h66);
        check("rm_wr_addr",  32'(link.bus_addr),  32'h0005);
        check("rm_wr_wdata", 32'(link.bus_wdata), 32'h66);
        ack_now(8'h00);
        check("rm_wr_reply", 32'(link.tx_byte), 32'h4B);
        tick();
        check("rm_tx_done",  32'(link.tx_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
